pipelined_rca_addsub: RTL and testbench

PIPELINED_RCA_ADDSUB -- requirements
Module: pipelined_rca_addsub

---
 rtl/pipelined_rca_addsub.sv | 128 ++++++++++++
 tb/tb_pipelined_rca_addsub.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds STAGE_BITS bits, and the carry is registered between stages.
// Latency is NSTG cycles. Results emerge in acceptance order, one per cycle.
// A stalled output freezes the whole pipeline. in_ready is the same as advance.
module pipelined_rca_addsub #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NSTG = WIDTH / STAGE_BITS;

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    assign b_eff    = SUB ? ~B : B;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSTG; k++) begin : stg
        localparam int DONE = (k + 1) * STAGE_BITS;
        localparam int REM  = WIDTH - DONE;

        logic [STAGE_BITS-1:0] a_in, b_in, s_bits;
        logic                  c_in, vld_in;
        logic [STAGE_BITS:0]   ch;
        logic [DONE-1:0]       sum_d, sum_q;
        logic                  c_d, c_q, vld_d, vld_q;

        // Stage 0 takes its operands from the ports. Later stages take them from the previous stage's registers.
        if (k == 0) begin : g_src
            assign a_in   = A[STAGE_BITS-1:0];
            assign b_in   = b_eff[STAGE_BITS-1:0];
            assign c_in   = Cin ^ SUB;
            assign vld_in = in_valid;
            always_comb sum_d = s_bits;
        end else begin : g_src
            assign a_in   = stg[k-1].g_rem.a_rem_q[STAGE_BITS-1:0];
            assign b_in   = stg[k-1].g_rem.b_rem_q[STAGE_BITS-1:0];
            assign c_in   = stg[k-1].c_q;
            assign vld_in = stg[k-1].vld_q;
            always_comb sum_d = {s_bits, stg[k-1].sum_q};
        end

        always_comb begin
            ch     = '0;
            s_bits = '0;
            ch[0]  = c_in;
            for (int i = 0; i < STAGE_BITS; i++) begin
                s_bits[i] = a_in[i] ^ b_in[i] ^ ch[i];
                ch[i+1]   = (a_in[i] & b_in[i]) | (ch[i] & (a_in[i] ^ b_in[i]));
            end
            c_d   = ch[STAGE_BITS];
            vld_d = vld_in;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_d;
                sum_q <= sum_d;
                c_q   <= c_d;
            end
        end

        // Operand bits that later stages have not yet added.
        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_rem_d, a_rem_q, b_rem_d, b_rem_q;

            if (k == 0) begin : g_ld
                always_comb begin
                    a_rem_d = A[WIDTH-1:STAGE_BITS];
                    b_rem_d = b_eff[WIDTH-1:STAGE_BITS];
                end
            end else begin : g_ld
                always_comb begin
                    a_rem_d = stg[k-1].g_rem.a_rem_q[REM+STAGE_BITS-1:STAGE_BITS];
                    b_rem_d = stg[k-1].g_rem.b_rem_q[REM+STAGE_BITS-1:STAGE_BITS];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (advance) begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        if (k == NSTG - 1) begin : g_last
            logic v_d, v_q;

            always_comb v_d = ch[STAGE_BITS] ^ ch[STAGE_BITS-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_d;
                end
            end
        end
    end

    assign S         = stg[NSTG-1].sum_q;
    assign Cout      = stg[NSTG-1].c_q;
    assign V         = stg[NSTG-1].g_last.v_q;
    assign out_valid = stg[NSTG-1].vld_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Bench for pipelined_rca_addsub: directed vectors feed a scoreboard queue, and a monitor checks every consumed result.
// It covers a 16-bit/4-stage instance and an 8-bit single-stage instance.
module tb_pipelined_rca_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a, b, s;
    logic        cin, sub, in_valid, in_ready, cout, v, out_valid, out_ready;
    logic [7:0]  a8, b8, s8;
    logic        cin8, sub8, in_valid8, in_ready8, cout8, v8, out_valid8, out_ready8;

    pipelined_rca_addsub #(.WIDTH(16), .STAGE_BITS(4)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .SUB(sub),
        .in_valid(in_valid), .in_ready(in_ready), .S(s), .Cout(cout), .V(v),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    pipelined_rca_addsub #(.WIDTH(8), .STAGE_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .SUB(sub8),
        .in_valid(in_valid8), .in_ready(in_ready8), .S(s8), .Cout(cout8), .V(v8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected16: got S=%h with no result pending", s);
            end else begin
                e = q16.pop_front();
                chk("S16", s, e.s);
                chk("Cout16", cout, e.c);
                chk("V16", v, e.v);
                if (e.lat) chk("latency16", cyc - e.acc, 3);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected8: got S=%h with no result pending", s8);
            end else begin
                e = q8.pop_front();
                chk("S8", s8, e.s);
                chk("Cout8", cout8, e.c);
                chk("V8", v8, e.v);
                chk("latency8", cyc - e.acc, 0);
            end
        end
    end

    // The task leaves in_valid high so that back-to-back calls issue on consecutive cycles.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic ev, input bit lat);
        int   n;
        exp_t e;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept16: in_ready stayed 0 for A=%h, expected 1", ta);
        end else begin
            e.s = es; e.c = ec; e.v = ev; e.acc = cyc + 1; e.lat = lat;
            q16.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                         input logic [7:0] es, input logic ec, input logic ev);
        exp_t e;
        a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; in_valid8 = 1'b1;
        chk("in_ready8", in_ready8, 1);
        e.s = {8'h00, es}; e.c = ec; e.v = ev; e.acc = cyc + 1; e.lat = 1'b1;
        q8.push_back(e);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain16", q16.size(), 0);
        chk("drain8", q8.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", s, 0);
        chk("rst_Cout", cout, 0);
        chk("rst_V", v, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", out_valid8, 0);
        @(posedge clk); #1;

        // Wraparound on add: the result must be valid for exactly one cycle.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("single_valid_once", out_valid, 0);
        @(posedge clk); #1;

        // Signed overflow on subtract and on add.
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;

        for (int i = 1; i <= 8; i++)
            send(16'(i), 16'(16'h0100 * i), 1'b0, 1'b0, 16'(16'h0101 * i), 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();

        // Fill the pipeline behind a stalled output.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        send(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        send(16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_S", s, 16'h3333);
            chk("stall_Cout", cout, 0);
            chk("stall_V", v, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("release_out_valid", out_valid, 1);
        end
        @(negedge clk);
        chk("release_done", out_valid, 0);
        chk("release_queue", q16.size(), 0);
        @(posedge clk); #1;

        // Reset with three operations in flight, and an attempted issue on the reset edge.
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
        send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
        q16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_S", s, 0);
            chk("post_rst_Cout", cout, 0);
            chk("post_rst_V", v, 0);
        end
        repeat (4) @(posedge clk);
        #1;

        // Single-stage instance: registered full-width add with latency 1.
        send8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        send8(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
